// File: rtl/parity_pkg.sv
// Shared types and constants for the odd-parity frame controller.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic ODD_GOOD = 1'b1;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/parity_frame_ctrl_acc.sv
// Running XOR accumulator with synchronous clear and enable.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/parity_frame_ctrl.sv
// Odd-parity serial frame controller.
// Error counter built only with PARITY_FRAME_CTRL_ERR_CNT_EN.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              bit_valid,
  input  logic              ser_in,
  input  logic              clr_cnt,
  output logic              busy,
  output logic              done,
  output logic              par_err,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic              acc_clr;
  logic              acc_en;

  assign acc_clr = (state == IDLE) && start;
  assign acc_en  = (state == DATA) && bit_valid && !abort;

  parity_acc u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (acc_en),
    .d   (ser_in),
    .acc (acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      par_err  <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= DATA;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        DATA: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_valid) begin
            shreg[cnt] <= ser_in;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST) state <= PAR;
          end
        end
        PAR: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_valid) begin
            state    <= DONE;
            done     <= 1'b1;
            par_err  <= (acc ^ ser_in) != ODD_GOOD;
            data_out <= shreg;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_FRAME_CTRL_ERR_CNT_EN
  // par_err already holds this frame's result while in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_cnt) begin
      err_cnt <= '0;
    end else if (state == DONE && par_err
                 && err_cnt != {CNT_W{1'b1}}) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_cnt;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Scoreboard bench for parity_frame_ctrl (DATA_W=8, CNT_W=8).
module tb_parity_frame_ctrl;

`ifdef PARITY_FRAME_CTRL_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       bit_valid = 1'b0;
  logic       ser_in = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       busy;
  logic       done;
  logic       par_err;
  logic [7:0] data_out;
  logic [7:0] err_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   m_cnt = 0;
  exp_t q[$];

  parity_frame_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bit_valid (bit_valid),
    .ser_in    (ser_in),
    .clr_cnt   (clr_cnt),
    .busy      (busy),
    .done      (done),
    .par_err   (par_err),
    .data_out  (data_out),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller sits 1 time unit after an edge; returns in the idle cycle after DONE.
  task automatic frame(input logic [7:0] d, input logic p,
                       input logic exp_bad, input int gap,
                       input logic clr, input logic st_done);
    exp_t       e;
    logic [8:0] bits;
    bits = {p, d};
    if (clr) m_cnt = 0;
    else if (exp_bad && CNT_EN && m_cnt != 255) m_cnt++;
    e.data = d;
    e.perr = exp_bad;
    e.cnt  = 8'(m_cnt);
    e.cyc  = cyc + 10 + 8 * gap;
    q.push_back(e);
    start = 1'b1;
    bit_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        bit_valid = 1'b0;
        repeat (gap) tick();
      end
      bit_valid = 1'b1;
      ser_in = bits[i];
      tick();
    end
    bit_valid = 1'b0;
    clr_cnt = clr;
    start = st_done;
    tick();
    clr_cnt = 1'b0;
    start = 1'b0;
  endtask

  // Monitor: done pops the scoreboard; err_cnt is checked one cycle later.
  initial begin
    logic pend;
    exp_t cur;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("err_cnt", {24'd0, err_cnt}, {24'd0, cur.cnt});
        pend = 1'b0;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = q.pop_front();
          chk("data_out", {24'd0, data_out}, {24'd0, cur.data});
          chk("par_err", {31'd0, par_err}, {31'd0, cur.perr});
          chk("done_cycle", cyc, cur.cyc);
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    chk("rst_data", {24'd0, data_out}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    #13;
    rst = 1'b0;
    tick();

    frame(8'h35, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    tick();
    chk("err_cnt_one", {24'd0, err_cnt}, CNT_EN ? 32'd1 : 32'd0);
    for (int i = 0; i < 255; i++) frame(8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    tick();
    chk("err_cnt_sat", {24'd0, err_cnt}, CNT_EN ? 32'd255 : 32'd0);
    frame(8'h07, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    tick();
    chk("err_cnt_clr", {24'd0, err_cnt}, 32'd0);

    frame(8'hA5, 1'b1, 1'b0, 2, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      ser_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {24'd0, data_out}, 32'hA5);
    repeat (3) tick();
    chk("abort_no_done_data", {24'd0, data_out}, 32'hA5);
    frame(8'h3C, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ser_in = 1'b0;
      tick();
    end
    bit_valid = 1'b0;
    tick();
    rst = 1'b1;
    m_cnt = 0;
    #1;
    chk("midpar_busy", {31'd0, busy}, 32'd0);
    chk("midpar_done", {31'd0, done}, 32'd0);
    chk("midpar_par_err", {31'd0, par_err}, 32'd0);
    chk("midpar_data", {24'd0, data_out}, 32'd0);
    chk("midpar_err_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    frame(8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("start_in_done_a", {31'd0, busy}, 32'd0);
    tick();
    chk("start_in_done_b", {31'd0, busy}, 32'd0);

    repeat (4) tick();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
